// File: rtl/tff_link_pkg.sv
// tff_link_pkg: shared types and constants for the toggle-encoded event link
package tff_link_pkg;
  typedef enum logic [1:0] {
    PRIME = 2'b00,
    ARMED = 2'b01
  } tff_state_t;
  localparam int TFF_SYNC_DEFAULT = 2;
endpackage

// File: rtl/toggle_pulse_decoder_sync_chain.sv
// sync_chain: resettable multi-flop synchroniser for a single asynchronous bit
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] s;
  always_ff @(posedge clk)
    if (rst) s <= '0;
    else s <= {s[SYNC_STAGES-2:0], d};
  assign q = s[SYNC_STAGES-1];
endmodule

// File: rtl/toggle_pulse_decoder.sv
// toggle_pulse_decoder: turns each level change of a toggle-encoded input into one pulse and counts them
module toggle_pulse_decoder
  import tff_link_pkg::*;
#(
  parameter int SYNC_STAGES = TFF_SYNC_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tog_in,
  input  logic             clr_cnt,
  output logic             pulse_out,
  output logic             level_out,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf
);
  tff_state_t state;
  logic [2:0] pcnt;
  logic prev;
  logic hit;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(tog_in),
    .q(level_out)
  );
  assign hit = (state == ARMED) & en & (level_out ^ prev);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
      pcnt <= '0;
      prev <= 1'b0;
      pulse_out <= 1'b0;
      evt_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      prev <= level_out;
      pulse_out <= hit;
      case (state)
        PRIME: begin
          pcnt <= pcnt + 3'd1;
          if (pcnt == 3'(SYNC_STAGES)) state <= ARMED;
        end
        ARMED: ;
        default: begin
          state <= PRIME;
          pcnt <= '0;
        end
      endcase
      // a clear coinciding with an event keeps that event
      if (clr_cnt) begin
        evt_cnt <= CNT_W'(hit);
        ovf <= 1'b0;
      end else if (hit) begin
        evt_cnt <= evt_cnt + 1'b1;
        if (&evt_cnt) ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// tb_toggle_pulse_decoder: directed scoreboard bench for toggle_pulse_decoder
module tb_toggle_pulse_decoder;
  typedef struct {
    int cyc;
    int cnt;
    int ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en, tog_in, clr_cnt;
  logic pulse_out, level_out, ovf;
  logic [7:0] evt_cnt;
  exp_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int mcnt = 0;
  int movf = 0;
  bit armed = 1'b1;
  bit mon_en = 1'b0;
  toggle_pulse_decoder #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .tog_in(tog_in),
    .clr_cnt(clr_cnt),
    .pulse_out(pulse_out),
    .level_out(level_out),
    .evt_cnt(evt_cnt),
    .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic toggle();
    exp_t e;
    tog_in = ~tog_in;
    if (armed && en) begin
      mcnt = (mcnt + 1) % 256;
      if (mcnt == 0) movf = 1;
      e.cyc = cyc + 3;
      e.cnt = mcnt;
      e.ovf = movf;
      q.push_back(e);
    end
  endtask
  task automatic clear();
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    mcnt = 0;
    movf = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    chk("drain_pending", q.size(), 0);
    tick(2);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) chk("idle_pulse", {31'd0, pulse_out}, 0);
      else if (pulse_out) begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_cnt", {24'd0, evt_cnt}, e.cnt);
        chk("pulse_ovf", {31'd0, ovf}, e.ovf);
      end
    end
  end
  initial begin
    exp_t e;
    rst = 1'b1;
    en = 1'b1;
    tog_in = 1'b1;
    clr_cnt = 1'b0;
    tick(2);
    mon_en = 1'b1;
    chk("rst_pulse", {31'd0, pulse_out}, 0);
    chk("rst_level", {31'd0, level_out}, 0);
    chk("rst_cnt", {24'd0, evt_cnt}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;
    tick(2);
    chk("prime_level", {31'd0, level_out}, 1);
    tick(6);
    chk("prime_cnt", {24'd0, evt_cnt}, 0);
    for (int i = 0; i < 4; i++) begin
      toggle();
      tick(3);
    end
    drain();
    chk("tff_cnt", {24'd0, evt_cnt}, 4);
    clear();
    for (int i = 0; i < 6; i++) begin
      toggle();
      tick(1);
    end
    drain();
    chk("b2b_cnt", {24'd0, evt_cnt}, 6);
    clear();
    en = 1'b0;
    toggle();
    tick(3);
    toggle();
    tick(6);
    en = 1'b1;
    tick(2);
    toggle();
    drain();
    chk("en_cnt", {24'd0, evt_cnt}, 1);
    clear();
    for (int i = 0; i < 256; i++) begin
      toggle();
      tick(1);
    end
    drain();
    chk("wrap_cnt", {24'd0, evt_cnt}, 0);
    chk("wrap_ovf", {31'd0, ovf}, 1);
    toggle();
    e = q.pop_back();
    e.cnt = 1;
    e.ovf = 0;
    q.push_back(e);
    mcnt = 1;
    movf = 0;
    tick(2);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    drain();
    chk("clr_cnt", {24'd0, evt_cnt}, 1);
    chk("clr_ovf", {31'd0, ovf}, 0);
    armed = 1'b0;
    toggle();
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    mcnt = 0;
    movf = 0;
    chk("rerst_cnt", {24'd0, evt_cnt}, 0);
    tick(8);
    chk("rerst_idle_cnt", {24'd0, evt_cnt}, 0);
    armed = 1'b1;
    toggle();
    drain();
    chk("rerst_pulse_cnt", {24'd0, evt_cnt}, 1);
    chk("final_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
